result_collector: RTL and testbench

//  Downstream of the dispatcher/worker array: gathers finished pixels (x, y, iteration count) from NUM_WORKERS

---
 rtl/result_collector_if.sv | 29 ++
 rtl/result_collector.sv | 207 ++++++++++++++++++++
 tb/tb_result_collector.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/result_collector_if.sv
// Worker-result lanes and frame-buffer write port of the result collector.
// slave = collector side, master = workers / frame buffer side.
interface result_collector_if #(
    parameter int NUM_WORKERS = 16,
    parameter int NUM_X_BITS  = 10,
    parameter int NUM_Y_BITS  = 10,
    parameter int ITER_BITS   = 8,
    parameter int ADDR_BITS   = 19
);
    logic [NUM_WORKERS-1:0]            res_valid;
    logic [NUM_WORKERS*NUM_X_BITS-1:0] res_x;
    logic [NUM_WORKERS*NUM_Y_BITS-1:0] res_y;
    logic [NUM_WORKERS*ITER_BITS-1:0]  res_iter;
    logic [NUM_WORKERS-1:0]            res_ack;
    logic                              fb_valid;
    logic                              fb_ready;
    logic [ADDR_BITS-1:0]              fb_addr;
    logic [ITER_BITS-1:0]              fb_data;

    modport slave (
        input  res_valid, res_x, res_y, res_iter, fb_ready,
        output res_ack, fb_valid, fb_addr, fb_data
    );

    modport master (
        output res_valid, res_x, res_y, res_iter, fb_ready,
        input  res_ack, fb_valid, fb_addr, fb_data
    );
endinterface

// File: rtl/result_collector.sv
// Round-robin collector of worker results into a FWFT FIFO feeding the frame buffer, with frame pixel counting.
// Optional stall counter output enabled by defining COLLECTOR_STALL_CNT_EN.
module result_collector #(
    parameter int NUM_WORKERS = 16,
    parameter int NUM_X_BITS  = 10,
    parameter int NUM_Y_BITS  = 10,
    parameter int ITER_BITS   = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int X_MAX       = 640,
    parameter int Y_MAX       = 480,
    parameter int ADDR_BITS   = 19
) (
    input  logic                        wr_clk,
    input  logic                        wr_rst,
    input  logic                        frame_start,
    result_collector_if.slave           bus,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_done
`ifdef COLLECTOR_STALL_CNT_EN
    ,
    output logic [15:0]                 stall_cycles
`endif
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
    localparam int PIX_W  = ADDR_BITS + 1;
    localparam int ENT_W  = ADDR_BITS + ITER_BITS;

    localparam logic [PIX_W-1:0]  FRAME_PIXELS = PIX_W'(X_MAX * Y_MAX);
    localparam logic [CNT_W-1:0]  FULL_COUNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [LANE_W-1:0] LAST_LANE    = LANE_W'(NUM_WORKERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [LANE_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic              frame_done_q, frame_done_d;

    logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];

    logic [NUM_X_BITS-1:0] lane_x    [NUM_WORKERS];
    logic [NUM_Y_BITS-1:0] lane_y    [NUM_WORKERS];
    logic [ITER_BITS-1:0]  lane_iter [NUM_WORKERS];

    generate
        for (genvar gi = 0; gi < NUM_WORKERS; gi++) begin : g_lane
            assign lane_x[gi]    = bus.res_x[gi*NUM_X_BITS +: NUM_X_BITS];
            assign lane_y[gi]    = bus.res_y[gi*NUM_Y_BITS +: NUM_Y_BITS];
            assign lane_iter[gi] = bus.res_iter[gi*ITER_BITS +: ITER_BITS];
        end
    endgenerate

    // Round-robin search: first valid lane at or after rr_ptr_q, wrapping.
    logic              grant_found;
    logic [LANE_W-1:0] grant_lane;
    always_comb begin
        int                idx;
        logic [LANE_W-1:0] cand;
        grant_found = 1'b0;
        grant_lane  = '0;
        idx         = 0;
        cand        = '0;
        for (int k = 0; k < NUM_WORKERS; k++) begin
            idx  = (int'(rr_ptr_q) + k) % NUM_WORKERS;
            cand = LANE_W'(idx);
            if (!grant_found && bus.res_valid[cand]) begin
                grant_found = 1'b1;
                grant_lane  = cand;
            end
        end
    end

    logic [NUM_X_BITS-1:0] grant_x;
    logic [NUM_Y_BITS-1:0] grant_y;
    logic [ITER_BITS-1:0]  grant_iter;
    logic [ADDR_BITS-1:0]  grant_addr;
    logic                  grant_in_range;

    assign grant_x        = lane_x[grant_lane];
    assign grant_y        = lane_y[grant_lane];
    assign grant_iter     = lane_iter[grant_lane];
    assign grant_addr     = ADDR_BITS'(grant_y) * ADDR_BITS'(X_MAX) + ADDR_BITS'(grant_x);
    assign grant_in_range = (32'(grant_x) < 32'(X_MAX)) && (32'(grant_y) < 32'(Y_MAX));

    // Full blocks a grant even when a pop frees a slot this same cycle.
    logic do_grant, do_push, do_pop, fifo_valid;
    assign fifo_valid = (count_q != '0);
    assign do_grant   = (state_q == ST_RUN) && !frame_start && grant_found && (count_q != FULL_COUNT);
    assign do_push    = do_grant && grant_in_range;
    assign do_pop     = fifo_valid && bus.fb_ready;

    always_comb begin
        bus.res_ack = '0;
        if (do_grant) begin
            bus.res_ack[grant_lane] = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        rr_ptr_d     = rr_ptr_q;
        pix_cnt_d    = pix_cnt_q;
        frame_done_d = 1'b0;
        if (frame_start) begin
            state_d   = ST_RUN;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            rr_ptr_d  = '0;
            pix_cnt_d = '0;
        end else begin
            if (do_grant) begin
                rr_ptr_d = (grant_lane == LAST_LANE) ? '0 : grant_lane + LANE_W'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            // Only pops while running count; leftovers drained after DONE are duplicates.
            if (do_pop && (state_q == ST_RUN)) begin
                if (pix_cnt_q + PIX_W'(1) == FRAME_PIXELS) begin
                    pix_cnt_d    = '0;
                    frame_done_d = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    pix_cnt_d = pix_cnt_q + PIX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rr_ptr_q     <= '0;
            pix_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rr_ptr_q     <= rr_ptr_d;
            pix_cnt_q    <= pix_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (do_push) begin
            fifo_mem[wr_ptr_q] <= {grant_addr, grant_iter};
        end
    end

    // Head is gated so stale storage never shows on the bus while empty.
    logic [ENT_W-1:0] head;
    assign head         = fifo_mem[rd_ptr_q];
    assign bus.fb_valid = fifo_valid;
    assign bus.fb_addr  = fifo_valid ? head[ENT_W-1:ITER_BITS] : '0;
    assign bus.fb_data  = fifo_valid ? head[ITER_BITS-1:0] : '0;
    assign fifo_count   = count_q;
    assign frame_done   = frame_done_q;

`ifdef COLLECTOR_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;
    always_comb begin
        stall_d = stall_q;
        if (frame_start) begin
            stall_d = '0;
        end else if (fifo_valid && !bus.fb_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_result_collector.sv
// Directed bench: a full-size collector for arbitration/FIFO behaviour and a 4x2-frame collector for end-of-frame.
module tb_result_collector;
    logic clk = 1'b0;
    logic rst;
    logic fs_a, fs_b;
    logic [3:0] count_a, count_b;
    logic done_a, done_b;
`ifdef COLLECTOR_STALL_CNT_EN
    logic [15:0] stall_a, stall_b;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    result_collector_if #(.NUM_WORKERS(16), .NUM_X_BITS(10), .NUM_Y_BITS(10), .ITER_BITS(8), .ADDR_BITS(19)) bus_a ();
    result_collector_if #(.NUM_WORKERS(16), .NUM_X_BITS(10), .NUM_Y_BITS(10), .ITER_BITS(8), .ADDR_BITS(19)) bus_b ();

    result_collector #(.X_MAX(640), .Y_MAX(480)) dut (
        .wr_clk      (clk),
        .wr_rst      (rst),
        .frame_start (fs_a),
        .bus         (bus_a.slave),
        .fifo_count  (count_a),
        .frame_done  (done_a)
`ifdef COLLECTOR_STALL_CNT_EN
        ,
        .stall_cycles(stall_a)
`endif
    );

    result_collector #(.X_MAX(4), .Y_MAX(2)) dut_small (
        .wr_clk      (clk),
        .wr_rst      (rst),
        .frame_start (fs_b),
        .bus         (bus_b.slave),
        .fifo_count  (count_b),
        .frame_done  (done_b)
`ifdef COLLECTOR_STALL_CNT_EN
        ,
        .stall_cycles(stall_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_a(input int lane, input int x, input int y, input int it);
        bus_a.res_valid[lane]       = 1'b1;
        bus_a.res_x[lane*10 +: 10]  = 10'(x);
        bus_a.res_y[lane*10 +: 10]  = 10'(y);
        bus_a.res_iter[lane*8 +: 8] = 8'(it);
    endtask

    task automatic set_b(input int lane, input int x, input int y, input int it);
        bus_b.res_valid[lane]       = 1'b1;
        bus_b.res_x[lane*10 +: 10]  = 10'(x);
        bus_b.res_y[lane*10 +: 10]  = 10'(y);
        bus_b.res_iter[lane*8 +: 8] = 8'(it);
    endtask

    initial begin
        int exp_rr[10];
        exp_rr = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};
        rst = 1'b1;
        fs_a = 1'b0;
        fs_b = 1'b0;
        bus_a.res_valid = '0; bus_a.res_x = '0; bus_a.res_y = '0; bus_a.res_iter = '0; bus_a.fb_ready = 1'b0;
        bus_b.res_valid = '0; bus_b.res_x = '0; bus_b.res_y = '0; bus_b.res_iter = '0; bus_b.fb_ready = 1'b0;
        tick();
        tick();

        // Reset values
        chk("rst_ack", 32'(bus_a.res_ack), 32'd0);
        chk("rst_fb_valid", 32'(bus_a.fb_valid), 32'd0);
        chk("rst_fb_addr", 32'(bus_a.fb_addr), 32'd0);
        chk("rst_fb_data", 32'(bus_a.fb_data), 32'd0);
        chk("rst_count", 32'(count_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_done_small", 32'(done_b), 32'd0);
`ifdef COLLECTOR_STALL_CNT_EN
        chk("rst_stall", 32'(stall_a), 32'd0);
`endif
        rst = 1'b0;

        // Single result from lane 3; IDLE does not ack, frame_start cycle does not ack
        set_a(3, 5, 2, 9);
        #1 chk("idle_no_ack", 32'(bus_a.res_ack), 32'd0);
        fs_a = 1'b1;
        #1 chk("fs_no_ack", 32'(bus_a.res_ack), 32'd0);
        tick();
        fs_a = 1'b0;
        #1 chk("lane3_ack", 32'(bus_a.res_ack), 32'h0008);
        tick();
        bus_a.res_valid = '0;
        #1 chk("lane3_fb_valid", 32'(bus_a.fb_valid), 32'd1);
        chk("lane3_fb_addr", 32'(bus_a.fb_addr), 32'd1285);
        chk("lane3_fb_data", 32'(bus_a.fb_data), 32'd9);
        chk("lane3_count", 32'(count_a), 32'd1);
        bus_a.fb_ready = 1'b1;
        tick();
        chk("lane3_popped_count", 32'(count_a), 32'd0);
        chk("lane3_popped_valid", 32'(bus_a.fb_valid), 32'd0);

        // Round robin over lanes 0,1,2, then lane 1 drops out
        for (int l = 0; l < 3; l++) set_a(l, l, 0, l + 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 6) bus_a.res_valid[1] = 1'b0;
            #1 chk($sformatf("rr_grant%0d", i), 32'(bus_a.res_ack), 32'd1 << exp_rr[i]);
            tick();
        end
        bus_a.res_valid = '0;
        tick();
        chk("rr_drained", 32'(count_a), 32'd0);

        // Backpressure: all lanes valid, FIFO fills after 8 grants starting at lane 3
        bus_a.fb_ready = 1'b0;
        for (int l = 0; l < 16; l++) set_a(l, l, 1, l);
        for (int i = 0; i < 8; i++) begin
            #1 chk($sformatf("fill_grant%0d", i), 32'(bus_a.res_ack), 32'd1 << (3 + i));
            tick();
        end
        chk("full_no_ack", 32'(bus_a.res_ack), 32'd0);
        chk("full_count", 32'(count_a), 32'd8);
        chk("full_head_addr", 32'(bus_a.fb_addr), 32'd643);
        chk("full_head_data", 32'(bus_a.fb_data), 32'd3);
        bus_a.fb_ready = 1'b1;
        #1 chk("full_pop_no_ack", 32'(bus_a.res_ack), 32'd0);
        tick();
        bus_a.fb_ready = 1'b0;
        #1 chk("after_pop_count", 32'(count_a), 32'd7);
        chk("after_pop_head", 32'(bus_a.fb_addr), 32'd644);
        chk("resume_ack", 32'(bus_a.res_ack), 32'd1 << 11);
        tick();
        chk("refull_count", 32'(count_a), 32'd8);
        chk("refull_no_ack", 32'(bus_a.res_ack), 32'd0);
        bus_a.res_valid = '0;
        bus_a.fb_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("full_drained", 32'(count_a), 32'd0);

        // Out-of-range coordinates: acked but discarded
        set_a(5, 640, 0, 1);
        #1 chk("oob_x_ack", 32'(bus_a.res_ack), 32'd1 << 5);
        tick();
        bus_a.res_valid = '0;
        #1 chk("oob_x_count", 32'(count_a), 32'd0);
        chk("oob_x_valid", 32'(bus_a.fb_valid), 32'd0);
        set_a(6, 0, 480, 1);
        #1 chk("oob_y_ack", 32'(bus_a.res_ack), 32'd1 << 6);
        tick();
        bus_a.res_valid = '0;
        #1 chk("oob_y_count", 32'(count_a), 32'd0);

        // Mid-frame frame_start flushes 5 entries and restarts arbitration at lane 0
        bus_a.fb_ready = 1'b0;
        set_a(7, 1, 1, 7);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_count5", 32'(count_a), 32'd5);
        chk("mid_head", 32'(bus_a.fb_addr), 32'd641);
        fs_a = 1'b1;
        #1 chk("mid_fs_no_ack", 32'(bus_a.res_ack), 32'd0);
        tick();
        fs_a = 1'b0;
        set_a(9, 2, 1, 9);
        #1 chk("mid_flush_count", 32'(count_a), 32'd0);
        chk("mid_flush_valid", 32'(bus_a.fb_valid), 32'd0);
        chk("mid_restart_lane", 32'(bus_a.res_ack), 32'd1 << 7);
`ifdef COLLECTOR_STALL_CNT_EN
        chk("mid_stall_clear", 32'(stall_a), 32'd0);
`endif
        bus_a.res_valid = '0;
        bus_a.fb_ready = 1'b1;

        // 4x2 frame on the small collector: frame_done after the 8th pop
        fs_b = 1'b1;
        tick();
        fs_b = 1'b0;
        bus_b.fb_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_b(0, i % 4, i / 4, i + 1);
            #1 chk($sformatf("small_ack%0d", i), 32'(bus_b.res_ack), 32'd1);
            tick();
        end
        bus_b.res_valid = '0;
        #1 chk("small_done_early", 32'(done_b), 32'd0);
        chk("small_last_addr", 32'(bus_b.fb_addr), 32'd7);
        chk("small_last_data", 32'(bus_b.fb_data), 32'd8);
        chk("small_last_count", 32'(count_b), 32'd1);
        tick();
        chk("small_done_pulse", 32'(done_b), 32'd1);
        chk("small_empty", 32'(count_b), 32'd0);
        set_b(0, 0, 0, 1);
        #1 chk("small_done_no_ack", 32'(bus_b.res_ack), 32'd0);
        tick();
        chk("small_done_single", 32'(done_b), 32'd0);
        chk("small_done_still_no_ack", 32'(bus_b.res_ack), 32'd0);
        fs_b = 1'b1;
        #1 chk("small_fs_no_ack", 32'(bus_b.res_ack), 32'd0);
        tick();
        fs_b = 1'b0;
        #1 chk("small_restart_ack", 32'(bus_b.res_ack), 32'd1);
        bus_b.res_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
